// File: rtl/weight_sram_arbiter.sv
// Arbitrates the single-port weight SRAM between the host and the EPU.
// Round-robin sharing normally; the EPU takes exclusive ownership while epu_run_i is high.
module weight_sram_arbiter #(
    parameter int ADDR_W = 17,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              epu_run_i,
    input  logic              h_req_i,
    input  logic              h_we_i,
    input  logic [ADDR_W-1:0] h_addr_i,
    input  logic [DATA_W-1:0] h_wdata_i,
    output logic              h_gnt_o,
    output logic              h_rvalid_o,
    output logic [DATA_W-1:0] h_rdata_o,
    input  logic              e_req_i,
    input  logic              e_we_i,
    input  logic [ADDR_W-1:0] e_addr_i,
    input  logic [DATA_W-1:0] e_wdata_i,
    output logic              e_gnt_o,
    output logic              e_rvalid_o,
    output logic [DATA_W-1:0] e_rdata_o,
    output logic              mem_cs_o,
    output logic              mem_oe_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              lock_o,
    output logic [15:0]       h_stall_cnt_o
);

    typedef enum logic [1:0] {SHARED, DRAIN, EPU_LOCK} state_t;

    state_t      state_q, state_d;
    logic        lastEpu_q, lastEpu_d;
    logic        rdValid_q, rdValid_d;
    logic        rdEpu_q, rdEpu_d;
    logic        lock_q;
    logic [15:0] stall_q, stall_d;
    logic        hGnt, eGnt, anyGnt, selWe, anyRead;

    // Grants are combinational and gated off entirely while reset is held.
    always_comb begin
        hGnt = 1'b0;
        eGnt = 1'b0;
        if (!rst) begin
            case (state_q)
                SHARED: begin
                    hGnt = h_req_i & (~e_req_i | lastEpu_q);
                    eGnt = e_req_i & ~hGnt;
                end
                EPU_LOCK: eGnt = e_req_i;
                default: ;
            endcase
        end
    end

    assign anyGnt  = hGnt | eGnt;
    assign selWe   = hGnt ? h_we_i : e_we_i;
    assign anyRead = anyGnt & ~selWe;

    assign h_gnt_o     = hGnt;
    assign e_gnt_o     = eGnt;
    assign mem_cs_o    = anyGnt;
    assign mem_oe_o    = anyRead;
    assign mem_we_o    = anyGnt & selWe;
    assign mem_addr_o  = hGnt ? h_addr_i : (eGnt ? e_addr_i : '0);
    assign mem_wdata_o = (anyGnt & selWe) ? (hGnt ? h_wdata_i : e_wdata_i) : '0;

    assign h_rvalid_o    = rdValid_q & ~rdEpu_q;
    assign e_rvalid_o    = rdValid_q & rdEpu_q;
    assign h_rdata_o     = h_rvalid_o ? mem_rdata_i : '0;
    assign e_rdata_o     = e_rvalid_o ? mem_rdata_i : '0;
    assign lock_o        = lock_q;
    assign h_stall_cnt_o = stall_q;

    // Next-state: a read granted on the cycle epu_run_i rises must drain before locking.
    always_comb begin
        rdValid_d = anyRead;
        rdEpu_d   = eGnt & ~e_we_i;
        lastEpu_d = eGnt ? 1'b1 : (hGnt ? 1'b0 : lastEpu_q);
        stall_d   = (h_req_i && !hGnt && stall_q != 16'hFFFF) ? stall_q + 16'd1 : stall_q;
        state_d   = state_q;
        case (state_q)
            SHARED:   if (epu_run_i) state_d = anyRead ? DRAIN : EPU_LOCK;
            DRAIN:    state_d = EPU_LOCK;
            EPU_LOCK: begin
                if (!epu_run_i) begin
                    state_d   = SHARED;
                    lastEpu_d = 1'b1;
                end
            end
            default:  state_d = SHARED;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= SHARED;
            lastEpu_q <= 1'b1;
            rdValid_q <= 1'b0;
            rdEpu_q   <= 1'b0;
            lock_q    <= 1'b0;
            stall_q   <= 16'd0;
        end else begin
            state_q   <= state_d;
            lastEpu_q <= lastEpu_d;
            rdValid_q <= rdValid_d;
            rdEpu_q   <= rdEpu_d;
            lock_q    <= (state_d == EPU_LOCK);
            stall_q   <= stall_d;
        end
    end

endmodule
